// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/click/double-click/long-press pulses.
// All outputs are registered, one cycle after the causing sample; no backpressure, one sample per clock.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DCLICK_CYCLES = 15_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic level_i,
  output logic held_o,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic double_click_o,
  output logic long_press_o
);

  localparam int MAX_CYCLES = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

  if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2) begin : g_bad_param
    $error("button_event_decoder: LONG_CYCLES and DCLICK_CYCLES must both be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          held_q, held_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          click_q, click_d;
  logic          dclick_q, dclick_d;
  logic          long_q, long_d;

  logic          rise, fall;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    held_d    = level_i;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;

    rise    = level_i & ~held_q;
    fall    = ~level_i & held_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // cnt holds the number of samples already spent in the current high/low phase
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = CNT_ONE;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = CNT_ONE;
          state_d   = WAIT_SECOND;
        end else if (level_i && cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_SECOND: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = CNT_ONE;
          state_d = SECOND_PRESSED;
        end else if (!level_i && cnt_q == DCLICK_LAST) begin
          click_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          dclick_d  = 1'b1;
          state_d   = IDLE;
        end else if (level_i && cnt_q == LONG_LAST) begin
          // first press is still owed its click; the second one became the long press
          click_d = 1'b1;
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
    end
  end

  assign held_o         = held_q;
  assign press_o        = press_q;
  assign release_o      = release_q;
  assign click_o        = click_q;
  assign double_click_o = dclick_q;
  assign long_press_o   = long_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: a run-length gesture model queues the expected output
// vector per sample; the monitor pops and compares it just after each rising edge.
module tb_button_event_decoder;

  localparam int LONG   = 20;
  localparam int DCLICK = 10;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic level_i;
  logic held_o, press_o, release_o, click_o, double_click_o, long_press_o;

  always #10 clk_i = ~clk_i;

  button_event_decoder #(
    .LONG_CYCLES  (LONG),
    .DCLICK_CYCLES(DCLICK)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .level_i       (level_i),
    .held_o        (held_o),
    .press_o       (press_o),
    .release_o     (release_o),
    .click_o       (click_o),
    .double_click_o(double_click_o),
    .long_press_o  (long_press_o)
  );

  int checks = 0;
  int errors = 0;
  int sample_no = 0;

  // {held, press, release, click, double_click, long_press}
  logic [5:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Gesture model, phrased as run lengths of high/low samples.
  logic m_prev;
  int   m_hi_len, m_lo_len;
  bit   m_wait_second, m_second, m_long_done;

  task automatic model_reset();
    m_prev        = 1'b0;
    m_hi_len      = 0;
    m_lo_len      = 0;
    m_wait_second = 1'b0;
    m_second      = 1'b0;
    m_long_done   = 1'b0;
  endtask

  function automatic logic [5:0] model_step(input logic lvl);
    logic p, r, c, dc, lp;
    p = 1'b0; r = 1'b0; c = 1'b0; dc = 1'b0; lp = 1'b0;
    if (lvl && !m_prev) begin
      p           = 1'b1;
      m_hi_len    = 1;
      m_long_done = 1'b0;
      m_second    = m_wait_second;
      m_wait_second = 1'b0;
    end else if (lvl) begin
      m_hi_len++;
      if (!m_long_done && m_hi_len == LONG) begin
        lp          = 1'b1;
        m_long_done = 1'b1;
        if (m_second) c = 1'b1;
        m_second    = 1'b0;
      end
    end else if (m_prev) begin
      r = 1'b1;
      if (m_second) begin
        dc       = 1'b1;
        m_second = 1'b0;
      end else if (!m_long_done) begin
        m_wait_second = 1'b1;
        m_lo_len      = 1;
      end
    end else if (m_wait_second) begin
      m_lo_len++;
      if (m_lo_len == DCLICK) begin
        c             = 1'b1;
        m_wait_second = 1'b0;
      end
    end
    m_prev = lvl;
    return {lvl, p, r, c, dc, lp};
  endfunction

  task automatic step(input logic lvl);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    level_i = lvl;
    sb_q.push_back(model_step(lvl));
  endtask

  task automatic seg(input logic lvl, input int n);
    repeat (n) step(lvl);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_held"},    {31'd0, held_o},         32'd0);
    check_eq({tag, "_press"},   {31'd0, press_o},        32'd0);
    check_eq({tag, "_release"}, {31'd0, release_o},      32'd0);
    check_eq({tag, "_click"},   {31'd0, click_o},        32'd0);
    check_eq({tag, "_dclick"},  {31'd0, double_click_o}, 32'd0);
    check_eq({tag, "_long"},    {31'd0, long_press_o},   32'd0);
  endtask

  // Asserted at a falling edge, when the previous sample has already been compared.
  task automatic do_reset(input int hold_cycles);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    check_outputs_zero("midreset");
    model_reset();
    repeat (hold_cycles) @(negedge clk_i);
  endtask

  always @(posedge clk_i) begin
    #1;
    if (sb_q.size() > 0) begin
      logic [5:0] exp_v;
      exp_v = sb_q.pop_front();
      sample_no++;
      check_eq($sformatf("sample%0d", sample_no),
               {26'd0, held_o, press_o, release_o, click_o, double_click_o, long_press_o},
               {26'd0, exp_v});
    end
  end

  initial begin
    rst_n_i = 1'b0;
    level_i = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("reset");

    seg(0, 50);                                           // idle, nothing fires
    seg(1, 5);  seg(0, 15);                               // single click
    seg(1, 5);  seg(0, 4);  seg(1, 5);  seg(0, 12);       // double click
    seg(1, 30); seg(0, 12);                               // long press
    seg(1, LONG - 1); seg(0, 12);                         // just short of long
    seg(1, LONG);     seg(0, 12);                         // exactly long
    seg(1, 5);  seg(0, DCLICK - 1); seg(1, 5); seg(0, 12);// last sample of window
    seg(1, 5);  seg(0, DCLICK);     seg(1, 5); seg(0, 12);// window missed: click then new press
    seg(1, 5);  seg(0, 3);  seg(1, 25); seg(0, 5);        // second press held long

    seg(1, 5);  seg(0, 3);                                // reset while waiting for second press
    do_reset(3);
    seg(0, 15);
    seg(1, 5);  seg(0, 3);
    do_reset(2);
    seg(1, 4);  seg(0, 15);                               // level high at reset release

    for (int i = 0; i < 40; i++) begin
      seg(1'($urandom_range(0, 1)), $urandom_range(1, 25));
    end
    seg(0, 15);

    @(posedge clk_i);
    #2;
    check_eq("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
